// File: rtl/fx_mac_ctrl.sv
// fx_mac_ctrl: command sequencer for the FX multiply-accumulate datapath.
// It takes one command at a time (cmd_valid/cmd_ready), holds the operands and
// the mode on the datapath for SETTLE_CYCLES cycles, then spends one ACT cycle
// sampling the datapath output and pulsing at most one accumulator strobe.
// The result is then held (res_valid/res_ready) until the consumer takes it.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   cmd_*                command handshake: op (MUL/MAC/CLR/PASS), sub, a, b
//   res_*                result handshake, 32-bit res_data
//   busy                 high in any state except IDLE
//   dp_*                 datapath operands, mode and strobes; dp_result comes back
//
// State | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETTLE| operands and mode held while the multiplier settles
// ACT   | one cycle: result sampled, accumulate/clear strobe high
// HOLD  | result presented until res_ready
module fx_mac_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_sub,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic [15:0] dp_a,
    output logic [15:0] dp_b,
    output logic        dp_mult_enabled,
    output logic        dp_add_or_sub,
    output logic        dp_reset_accum,
    output logic        dp_accumulate,
    input  logic [31:0] dp_result
);

    typedef enum logic [1:0] {IDLE, SETTLE, ACT, HOLD} state_t;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MAC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    localparam logic [2:0] CNT_INIT = 3'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [1:0]  op, op_nxt;
    logic [2:0]  cnt, cnt_nxt;

    logic        cmd_ready_nxt, res_valid_nxt, busy_nxt;
    logic [31:0] res_data_nxt;
    logic [15:0] dp_a_nxt, dp_b_nxt;
    logic        dp_mult_enabled_nxt, dp_add_or_sub_nxt;
    logic        dp_reset_accum_nxt, dp_accumulate_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            op              <= OP_MUL;
            cnt             <= '0;
            cmd_ready       <= 1'b1;
            res_valid       <= 1'b0;
            res_data        <= '0;
            busy            <= 1'b0;
            dp_a            <= '0;
            dp_b            <= '0;
            dp_mult_enabled <= 1'b0;
            dp_add_or_sub   <= 1'b0;
            dp_reset_accum  <= 1'b0;
            dp_accumulate   <= 1'b0;
        end else begin
            state           <= state_nxt;
            op              <= op_nxt;
            cnt             <= cnt_nxt;
            cmd_ready       <= cmd_ready_nxt;
            res_valid       <= res_valid_nxt;
            res_data        <= res_data_nxt;
            busy            <= busy_nxt;
            dp_a            <= dp_a_nxt;
            dp_b            <= dp_b_nxt;
            dp_mult_enabled <= dp_mult_enabled_nxt;
            dp_add_or_sub   <= dp_add_or_sub_nxt;
            dp_reset_accum  <= dp_reset_accum_nxt;
            dp_accumulate   <= dp_accumulate_nxt;
        end
    end

    // Every output is registered, so this block computes the value each output
    // takes after the coming edge. The strobes are raised on the way into ACT
    // so they are high exactly during the ACT cycle.
    always_comb begin
        state_nxt           = state;
        op_nxt              = op;
        cnt_nxt             = cnt;
        res_valid_nxt       = res_valid;
        res_data_nxt        = res_data;
        dp_a_nxt            = dp_a;
        dp_b_nxt            = dp_b;
        dp_mult_enabled_nxt = dp_mult_enabled;
        dp_add_or_sub_nxt   = dp_add_or_sub;
        dp_reset_accum_nxt  = 1'b0;
        dp_accumulate_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt              = cmd_op;
                    dp_a_nxt            = cmd_a;
                    dp_b_nxt            = cmd_b;
                    dp_mult_enabled_nxt = (cmd_op != OP_PASS);
                    dp_add_or_sub_nxt   = (cmd_op == OP_MAC) && cmd_sub;
                    cnt_nxt             = CNT_INIT;
                    state_nxt           = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 3'd0) begin
                    state_nxt          = ACT;
                    dp_accumulate_nxt  = (op == OP_MAC);
                    dp_reset_accum_nxt = (op == OP_CLR);
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ACT: begin
                // dp_result here is the combinational adder output, i.e. the
                // value the accumulator captures on this same edge for MAC.
                case (op)
                    OP_CLR:  res_data_nxt = '0;
                    OP_PASS: res_data_nxt = {dp_b, dp_a};
                    default: res_data_nxt = dp_result;
                endcase
                res_valid_nxt = 1'b1;
                state_nxt     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_fx_mac_ctrl.sv
module tb_fx_mac_ctrl;

    localparam logic [1:0] MUL = 2'b00, MAC = 2'b01, CLR = 2'b10, PASS = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        reset;
    // instance with SETTLE_CYCLES=1
    logic        cmd_valid = 0, cmd_ready, cmd_sub = 0, res_valid, res_ready = 0, busy;
    logic [1:0]  cmd_op = 0;
    logic [15:0] cmd_a = 0, cmd_b = 0, dp_a, dp_b;
    logic [31:0] res_data, dp_result;
    logic        dp_mult_enabled, dp_add_or_sub, dp_reset_accum, dp_accumulate;
    // instance with SETTLE_CYCLES=4
    logic        q_cmd_valid = 0, q_cmd_ready, q_cmd_sub = 0, q_res_valid, q_res_ready = 0, q_busy;
    logic [1:0]  q_cmd_op = 0;
    logic [15:0] q_cmd_a = 0, q_cmd_b = 0, q_dp_a, q_dp_b;
    logic [31:0] q_res_data, q_dp_result;
    logic        q_dp_mult_enabled, q_dp_add_or_sub, q_dp_reset_accum, q_dp_accumulate;

    fx_mac_ctrl #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sub(cmd_sub), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy),
        .dp_a(dp_a), .dp_b(dp_b), .dp_mult_enabled(dp_mult_enabled),
        .dp_add_or_sub(dp_add_or_sub), .dp_reset_accum(dp_reset_accum),
        .dp_accumulate(dp_accumulate), .dp_result(dp_result));

    fx_mac_ctrl #(.SETTLE_CYCLES(4)) u4 (
        .clk(clk), .reset(reset), .cmd_valid(q_cmd_valid), .cmd_ready(q_cmd_ready),
        .cmd_op(q_cmd_op), .cmd_sub(q_cmd_sub), .cmd_a(q_cmd_a), .cmd_b(q_cmd_b),
        .res_valid(q_res_valid), .res_ready(q_res_ready), .res_data(q_res_data), .busy(q_busy),
        .dp_a(q_dp_a), .dp_b(q_dp_b), .dp_mult_enabled(q_dp_mult_enabled),
        .dp_add_or_sub(q_dp_add_or_sub), .dp_reset_accum(q_dp_reset_accum),
        .dp_accumulate(q_dp_accumulate), .dp_result(q_dp_result));

    // Datapath models: signed 16x16 product, accumulator +/- product on an
    // unregistered adder, accumulator not affected by the controller reset.
    logic        [31:0] acc1 = '0, acc4 = '0;
    logic signed [31:0] prod1, prod4;
    always_comb begin
        prod1 = dp_mult_enabled ? $signed(dp_a) * $signed(dp_b) : 32'sd0;
        dp_result = dp_add_or_sub ? acc1 - prod1 : acc1 + prod1;
        prod4 = q_dp_mult_enabled ? $signed(q_dp_a) * $signed(q_dp_b) : 32'sd0;
        q_dp_result = q_dp_add_or_sub ? acc4 - prod4 : acc4 + prod4;
    end

    int n_acc = 0, n_clr = 0, n_both = 0, q_n_strobe = 0;
    always @(posedge clk) begin
        if (dp_reset_accum) acc1 <= '0;
        else if (dp_accumulate) acc1 <= dp_result;
        if (q_dp_reset_accum) acc4 <= '0;
        else if (q_dp_accumulate) acc4 <= q_dp_result;
        if (dp_accumulate) n_acc <= n_acc + 1;
        if (dp_reset_accum) n_clr <= n_clr + 1;
        if (dp_accumulate && dp_reset_accum) n_both <= n_both + 1;
        if (q_dp_accumulate || q_dp_reset_accum) q_n_strobe <= q_n_strobe + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command on u1, wait for the result, check it and hand it off.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic sub,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
        int n, acc0, clr0;
        logic me_seen, stable;
        acc0 = n_acc;
        clr0 = n_clr;
        cmd_op = op; cmd_sub = sub; cmd_a = a; cmd_b = b; cmd_valid = 1;
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0; me_seen = 0; stable = 1;
        while (!res_valid && n < 50) begin
            me_seen |= dp_mult_enabled;
            if (dp_a !== a || dp_b !== b) stable = 0;
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd2);
        chk({tag, " res_data"}, res_data, exp);
        chk({tag, " acc pulses"}, 32'(n_acc - acc0), 32'(op == MAC));
        chk({tag, " clr pulses"}, 32'(n_clr - clr0), 32'(op == CLR));
        chk({tag, " mult_en"}, 32'(me_seen), 32'(op != PASS));
        chk({tag, " operands stable"}, 32'(stable), 32'd1);
        res_ready = 1;
        tick();
        res_ready = 0;
        chk({tag, " res_valid after"}, 32'(res_valid), 32'd0);
        chk({tag, " cmd_ready after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n, acc0;
        logic stable;

        reset = 1;
        repeat (3) tick();
        reset = 0;
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data", res_data, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst dp_ab", {dp_b, dp_a}, 32'd0);
        chk("rst strobes", {28'd0, dp_mult_enabled, dp_add_or_sub, dp_reset_accum, dp_accumulate}, 32'd0);

        run_cmd("mul3x-2", MUL, 0, 16'h0003, 16'hFFFE, 32'hFFFF_FFFA);
        run_cmd("clr", CLR, 0, 16'h0000, 16'h0000, 32'h0000_0000);
        run_cmd("mac+", MAC, 0, 16'd100, 16'd200, 32'h0000_4E20);
        run_cmd("mac-", MAC, 1, 16'd10, 16'd10, 32'h0000_4DBC);
        run_cmd("pass", PASS, 0, 16'h1234, 16'hABCD, 32'hABCD_1234);
        run_cmd("mac0 after pass", MAC, 0, 16'd0, 16'd0, 32'h0000_4DBC);

        // Result back-pressure with a second command waiting.
        cmd_op = PASS; cmd_a = 16'h0001; cmd_b = 16'h0002; cmd_valid = 1;
        tick();
        cmd_a = 16'h0005; cmd_b = 16'h0006;
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("bp first res_data", res_data, 32'h0002_0001);
        stable = 1;
        repeat (5) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== 32'h0002_0001 || cmd_ready !== 1'b0) stable = 0;
        end
        chk("bp hold stable", 32'(stable), 32'd1);
        res_ready = 1;
        tick();
        res_ready = 0;
        chk("bp no accept at handoff", {30'd0, busy, cmd_ready}, 32'b01);
        tick();
        chk("bp accept next cycle", {30'd0, busy, cmd_ready}, 32'b10);
        chk("bp second operands", {dp_b, dp_a}, 32'h0006_0005);
        cmd_valid = 0;
        n = 0;
        while (!res_valid && n < 50) begin tick(); n++; end
        chk("bp second res_data", res_data, 32'h0006_0005);
        res_ready = 1;
        tick();
        res_ready = 0;

        // Reset during SETTLE aborts a MAC without a strobe.
        acc0 = n_acc;
        cmd_op = MAC; cmd_sub = 0; cmd_a = 16'd1; cmd_b = 16'd1; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        chk("abort accepted", 32'(busy), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("abort outputs", {busy, cmd_ready, res_valid, dp_mult_enabled, dp_add_or_sub,
                              dp_reset_accum, dp_accumulate}, 32'b0100000);
        chk("abort dp_ab", {dp_b, dp_a}, 32'd0);
        chk("abort res_data", res_data, 32'd0);
        tick();
        tick();
        chk("abort no pulse", 32'(n_acc - acc0), 32'd0);
        run_cmd("mac0 after abort", MAC, 0, 16'd0, 16'd0, 32'h0000_4DBC);

        // SETTLE_CYCLES=4 instance.
        q_cmd_op = MUL; q_cmd_a = 16'h8000; q_cmd_b = 16'h8000; q_cmd_valid = 1;
        tick();
        q_cmd_valid = 0;
        n = 0; stable = 1;
        while (!q_res_valid && n < 50) begin
            if (q_dp_a !== 16'h8000 || q_dp_b !== 16'h8000) stable = 0;
            tick();
            n++;
        end
        chk("s4 latency", 32'(n), 32'd5);
        chk("s4 res_data", q_res_data, 32'h4000_0000);
        chk("s4 operands stable", 32'(stable), 32'd1);
        chk("s4 no strobe", 32'(q_n_strobe), 32'd0);
        q_res_ready = 1;
        tick();
        q_res_ready = 0;
        chk("s4 handoff", {30'd0, q_res_valid, q_cmd_ready}, 32'b01);

        chk("strobe exclusivity", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
